aes_result_reader: RTL
======================

# aes_result_reader

Receive-side companion of the AES top block: samples the 128-bit ciphertext presented on `AES_data_out` when `AES_data_out_valid` rises and buffers whole blocks in a small FIFO. It drains each block as four 32-bit words over a valid/ready stream toward a host or bus bridge. The AES core has no back-pressure, so the reader absorbs bursts and flags any block it had to drop.

## Interface
- `DEPTH`, default 2: FIFO depth in 128-bit blocks; power of two, at least 2.
- `AES_clk`  in  1: sole clock; all state changes on rising edge.
- `AES_rst`  in  1: asynchronous, active-high reset.
- `AES_data_out_valid`  in  1: result-valid from the AES core; may be held high for several cycles.
- `AES_data_out`  in  128: ciphertext block; `[127:96]` is word 0.
- `rd_data`  out  32: current output word.
- `rd_valid`  out  1: `rd_data` is valid.
- `rd_ready`  in  1: sink accepts the word when high together with `rd_valid`.
- `rd_last`  out  1: high with the 4th word (word 3) of a block.
- `blk_count`  out  clog2(DEPTH)+1: number of blocks stored, including any partially drained block.
- `overflow`  out  1: sticky; a block was dropped because the FIFO was full.
- `ovf_clr`  in  1: synchronous clear of `overflow`.

## Operation
- Capture:
  - A capture event occurs when `AES_data_out_valid` is high at an edge and its registered previous value `prev_valid` is low. This is rising-edge detection.
  - On a capture event the full 128-bit `AES_data_out` is written at the write pointer, and the write pointer increments.
  - A valid level held for N cycles produces exactly one capture.
- FIFO:
  - Read and write pointers are clog2(DEPTH)+1 bits wide, with natural wrap.
  - Empty: pointers are equal.
  - Full: pointer MSBs differ and the remaining bits are equal.
  - `blk_count` = wr_ptr − rd_ptr, computed modulo 2^(clog2(DEPTH)+1).
- Drain:
  - 2-bit `word_idx` selects the output word: 0 selects `[127:96]`, 3 selects `[31:0]`.
  - `rd_valid` = not empty.
  - `rd_data` = word `word_idx` of the block at `rd_ptr`, read combinationally from storage.
  - On a transfer (`rd_valid` and `rd_ready` both high), `word_idx` increments.
  - On a transfer with `word_idx`==3: `word_idx` returns to 0, `rd_ptr` increments and the block is freed.
  - `rd_last` = `rd_valid` and (`word_idx`==3).
- Overflow:
  - A capture event while full drops the incoming block and sets `overflow`.
  - Exception: if a word-3 transfer frees a slot in the same cycle, the capture is accepted and `overflow` does not set.
  - `ovf_clr` clears `overflow`. If `ovf_clr` and a dropping capture occur in the same cycle, set wins.
- Simultaneous capture and block release when not full: both pointers move and `blk_count` is unchanged.
- Once `rd_valid` is high, `rd_data` and `rd_last` stay stable until the word transfers.

## Timing
- Reset values:
  - `rd_valid`=0, `rd_last`=0, `rd_data`=0 (storage cleared), `blk_count`=0, `overflow`=0.
  - Internally: `word_idx`=0, `prev_valid`=0, both pointers 0.
- Latency: a capture at edge k gives `rd_valid`=1 with word 0 in the cycle after edge k.
- Throughput: one word per cycle with `rd_ready` held high, so 4 cycles per block.
- Reset mid-operation clears everything immediately, including any partially drained block. No output persists.
- `AES_data_out_valid` already high when reset releases: `prev_valid`=0, so one capture occurs at the first edge.

## Configuration
- `AES_READER_BYTE_SWAP_EN`:
  - Defined: each output word is byte-reversed, so `rd_data` = {w[7:0], w[15:8], w[23:16], w[31:24]}, where w is the selected word. This suits little-endian hosts.
  - Undefined: words pass through unmodified.
- Word order, `rd_last` and all timing are identical in both builds.

## Test plan
- Single block:
  - Stimulus: `AES_data_out`=128'h00112233_44556677_8899aabb_ccddeeff, with valid high for 1 cycle and `rd_ready`=1.
  - Response: `rd_data` = 00112233, 44556677, 8899aabb, ccddeeff on 4 consecutive cycles, with `rd_last` on the 4th word and `blk_count` going 1 then 0.
- Held valid: valid high for 5 cycles → exactly one block captured and `blk_count` peaks at 1.
- Back-pressure:
  - Stimulus: `rd_ready` toggles 1,0,1,0…
  - Response: each word holds while `rd_ready`=0, no word is skipped or duplicated, and the 4 words complete in 7 cycles.
- Overflow:
  - Stimulus: DEPTH=2, `rd_ready`=0, three separate valid pulses with blocks A, B, C.
  - Response: `blk_count`=2 and `overflow`=1. After releasing `rd_ready`, only A then B drain. `ovf_clr` then clears `overflow`.
- Full with simultaneous free:
  - Stimulus: FIFO full and a capture event in the same cycle as a word-3 transfer.
  - Response: the new block is accepted, `overflow` stays 0 and `blk_count` stays 2.
- Reset mid-drain: assert `AES_rst` after word 1 of a block → outputs return to reset values at once, and after release the next block starts at word 0. Repeat the single-block case with `AES_READER_BYTE_SWAP_EN` defined → first word is 33221100.

Source files
------------

// File: rtl/aes_result_reader.sv
// Captures AES result blocks on the rising edge of AES_data_out_valid into a block FIFO
// and drains them as four 32-bit words over valid/ready. Optional macro: AES_READER_BYTE_SWAP_EN.
module aes_result_reader #(
   parameter int DEPTH = 2
) (
   input  logic                     AES_clk,
   input  logic                     AES_rst,
   input  logic                     AES_data_out_valid,
   input  logic [127:0]             AES_data_out,
   output logic [31:0]              rd_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic                     rd_last,
   output logic [$clog2(DEPTH):0]   blk_count,
   output logic                     overflow,
   input  logic                     ovf_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [127:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [1:0]   word_idx;
   logic         prev_valid;

   logic         empty;
   logic         full;
   logic         capture;
   logic         xfer;
   logic         release_blk;
   logic         accept;
   logic         drop;
   logic [31:0]  word;

   function automatic logic [31:0] sel_word(input logic [127:0] blk, input logic [1:0] idx);
      case (idx)
         2'd0:    return blk[127:96];
         2'd1:    return blk[95:64];
         2'd2:    return blk[63:32];
         default: return blk[31:0];
      endcase
   endfunction

   function automatic logic [31:0] byte_swap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   assign empty       = (wr_ptr == rd_ptr);
   assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign capture     = AES_data_out_valid && !prev_valid;
   assign xfer        = rd_valid && rd_ready;
   assign release_blk = xfer && (word_idx == 2'd3);
   // A word-3 transfer frees the head slot in the same edge, so a full FIFO can still accept.
   assign accept      = capture && (!full || release_blk);
   assign drop        = capture && full && !release_blk;

   assign rd_valid  = !empty;
   assign rd_last   = rd_valid && (word_idx == 2'd3);
   assign blk_count = wr_ptr - rd_ptr;
   assign word      = sel_word(mem[rd_ptr[AW-1:0]], word_idx);

`ifdef AES_READER_BYTE_SWAP_EN
   assign rd_data = byte_swap(word);
`else
   assign rd_data = word;
`endif

   // Capture side: edge detect and block write.
   always_ff @(posedge AES_clk or posedge AES_rst) begin
      if (AES_rst) begin
         prev_valid <= 1'b0;
         wr_ptr     <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         prev_valid <= AES_data_out_valid;
         if (accept) begin
            mem[wr_ptr[AW-1:0]] <= AES_data_out;
            wr_ptr              <= wr_ptr + PTR_ONE;
         end
      end
   end

   // Drain side: word index and block release.
   always_ff @(posedge AES_clk or posedge AES_rst) begin
      if (AES_rst) begin
         rd_ptr   <= '0;
         word_idx <= 2'd0;
      end else if (xfer) begin
         word_idx <= word_idx + 2'd1;
         if (release_blk) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge AES_clk or posedge AES_rst) begin
      if (AES_rst)      overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
   end

endmodule
